// File: rtl/trig_cnt_pkg.sv
// Shared types and default widths for the dual-trigger window counter.
//   win_state_t : window FSM state encoding
//   CNT_W_DEF   : default edge counter width
//   WIN_W_DEF   : default window length width
//   NUM_CH      : number of trigger channels handled by the top level
package trig_cnt_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int WIN_W_DEF = 16;
    localparam int NUM_CH    = 2;

    typedef enum logic [1:0] {IDLE, RUN, REPORT} win_state_t;

endpackage

// File: rtl/rise_counter.sv
// One trigger channel: rising-edge detector, saturating edge counter and
// overflow flag.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : clear counter and ovf (window start)
//   en       : count edges this cycle
//   trig     : trigger level input
//   cnt      : live saturating edge count
//   ovf      : an edge arrived while cnt was already at max
module rise_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             trig,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic prev;
    logic rise;

    assign rise = trig & ~prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            // History tracks the input in every state so a level held
            // across the window start never looks like a fresh edge.
            prev <= trig;
            if (clr) begin
                cnt <= '0;
                ovf <= 1'b0;
            end else if (en && rise) begin
                if (cnt == '1) ovf <= 1'b1;
                else           cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dual_trigger_window_counter.sv
// Counts rising edges on two trigger streams over a programmable window and
// publishes both counts with a one-cycle done pulse when the window closes.
//   clk, rst       : clock, asynchronous active-high reset
//   start, win_len : open a window of win_len cycles (IDLE only, len != 0)
//   stop           : close the running window early
//   trig1, trig2   : trigger levels, synchronous to clk
//   busy           : window running
//   done           : one-cycle report pulse
//   count1/2       : edge counts of the last window
//   ovf1/2         : count saturated during the last window
module dual_trigger_window_counter
    import trig_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             stop,
    input  logic             trig1,
    input  logic             trig2,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic             ovf1,
    output logic             ovf2
);

    win_state_t state, state_nxt;
    logic [WIN_W-1:0] timer;
    logic             accept;

    logic [NUM_CH-1:0]            trig_v;
    logic [NUM_CH-1:0][CNT_W-1:0] live_cnt, held_cnt;
    logic [NUM_CH-1:0]            live_ovf, held_ovf;

    assign trig_v = {trig2, trig1};
    assign accept = (state == IDLE) && start && (win_len != '0);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        rise_counter #(.CNT_W(CNT_W)) u_ch (
            .clk  (clk),
            .rst  (rst),
            .clr  (accept),
            .en   (state == RUN),
            .trig (trig_v[gi]),
            .cnt  (live_cnt[gi]),
            .ovf  (live_ovf[gi])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (timer == WIN_W'(1) || stop) state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer    <= '0;
            held_cnt <= '0;
            held_ovf <= '0;
        end else begin
            if (accept)            timer <= win_len;
            else if (state == RUN) timer <= timer - 1'b1;
            if (state == REPORT) begin
                held_cnt <= live_cnt;
                held_ovf <= live_ovf;
            end
        end
    end

    // Live counters are frozen during REPORT, so showing them directly makes
    // the new result visible in the done cycle; the latch holds it afterwards
    // while the next window clears and refills the live counters.
    assign busy   = (state == RUN);
    assign done   = (state == REPORT);
    assign count1 = done ? live_cnt[0] : held_cnt[0];
    assign count2 = done ? live_cnt[1] : held_cnt[1];
    assign ovf1   = done ? live_ovf[0] : held_ovf[0];
    assign ovf2   = done ? live_ovf[1] : held_ovf[1];

endmodule

// File: tb/tb_dual_trigger_window_counter.sv
module tb_dual_trigger_window_counter;

    logic        clk = 1'b0;
    logic        rst, start, stop, trig1, trig2;
    logic [15:0] win_len;

    logic        w_busy, w_done, w_o1, w_o2;
    logic [15:0] w_c1, w_c2;
    logic        n_busy, n_done, n_o1, n_o2;
    logic [3:0]  n_c1, n_c2;

    dual_trigger_window_counter u_wide (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .stop(stop),
        .trig1(trig1), .trig2(trig2), .busy(w_busy), .done(w_done),
        .count1(w_c1), .count2(w_c2), .ovf1(w_o1), .ovf2(w_o2));

    dual_trigger_window_counter #(.CNT_W(4)) u_nar (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len), .stop(stop),
        .trig1(trig1), .trig2(trig2), .busy(n_busy), .done(n_done),
        .count1(n_c1), .count2(n_c2), .ovf1(n_o1), .ovf2(n_o2));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int s, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (s > mx) ? mx : s;
    endfunction

    // Window-level model: a window is a run of remaining cycles; edges inside
    // it are summed as plain integers and saturated only when reported.
    bit m_run, m_rep, p1, p2;
    int m_rem, s1, s2, h1, h2;

    always @(posedge clk) begin
        bit rep_now, e1, e2;
        if (rst) begin
            m_run = 0; m_rep = 0; p1 = 0; p2 = 0;
            m_rem = 0; s1 = 0; s2 = 0; h1 = 0; h2 = 0;
        end else begin
            e1 = trig1 & ~p1;
            e2 = trig2 & ~p2;
            rep_now = m_rep;
            m_rep = 0;
            if (m_run) begin
                s1 += int'(e1);
                s2 += int'(e2);
                m_rem--;
                if (m_rem == 0 || stop) begin
                    m_run = 0;
                    m_rep = 1;
                    h1 = s1;
                    h2 = s2;
                end
            end else if (!rep_now && start && win_len != 0) begin
                m_run = 1;
                m_rem = int'(win_len);
                s1 = 0;
                s2 = 0;
            end
            p1 = trig1;
            p2 = trig2;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_w_busy", w_busy, 0); chk("rst_w_done", w_done, 0);
            chk("rst_w_c1", w_c1, 0);     chk("rst_w_c2", w_c2, 0);
            chk("rst_w_o1", w_o1, 0);     chk("rst_w_o2", w_o2, 0);
            chk("rst_n_c1", n_c1, 0);     chk("rst_n_o1", n_o1, 0);
        end else begin
            chk("w_busy", w_busy, m_run); chk("w_done", w_done, m_rep);
            chk("w_c1", w_c1, sat(h1, 16)); chk("w_c2", w_c2, sat(h2, 16));
            chk("w_o1", w_o1, h1 > 65535);  chk("w_o2", w_o2, h2 > 65535);
            chk("n_busy", n_busy, m_run); chk("n_done", n_done, m_rep);
            chk("n_c1", n_c1, sat(h1, 4)); chk("n_c2", n_c2, sat(h2, 4));
            chk("n_o1", n_o1, h1 > 15);    chk("n_o2", n_o2, h2 > 15);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Periodic 1-cycle pulses at RUN cycles 1, 1+per, ...; optional stop.
    task automatic window(input string nm, input int len, input int per1, input int per2,
                          input int stop_at, input int wc1, input int wc2,
                          input int nc1, input bit no1);
        start = 1; win_len = 16'(len);
        step();
        start = 0;
        for (int k = 1; k <= len; k++) begin
            trig1 = (per1 > 0) && ((k - 1) % per1 == 0);
            trig2 = (per2 > 0) && ((k - 1) % per2 == 0);
            stop  = (k == stop_at);
            step();
            if (k == stop_at) break;
        end
        trig1 = 0; trig2 = 0; stop = 0;
        @(negedge clk);
        chk({nm, "_done"}, w_done, 1);
        chk({nm, "_wc1"}, w_c1, wc1);
        chk({nm, "_wc2"}, w_c2, wc2);
        chk({nm, "_nc1"}, n_c1, nc1);
        chk({nm, "_no1"}, n_o1, no1);
        step();
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; trig1 = 0; trig2 = 0; win_len = '0;
        step(); step();
        rst = 0;
        step();

        window("nominal", 200, 20, 40, 0, 10, 5, 10, 0);
        window("sat", 200, 10, 0, 0, 20, 0, 15, 1);
        window("stop", 200, 20, 40, 100, 5, 3, 5, 0);

        // Reset in the middle of a window.
        start = 1; win_len = 16'd200;
        step();
        start = 0;
        for (int k = 1; k < 50; k++) begin
            trig1 = (k % 7 == 1);
            step();
        end
        rst = 1; trig1 = 0;
        @(negedge clk);
        chk("rstmid_busy", w_busy, 0);
        chk("rstmid_done", w_done, 0);
        chk("rstmid_c1", w_c1, 0);
        step();
        rst = 0;
        step();
        window("clean", 30, 5, 7, 0, 6, 5, 6, 0);

        // trig1 high before start stays high: no edge.
        trig1 = 1;
        step();
        start = 1; win_len = 16'd10;
        step();
        start = 0;
        repeat (10) step();
        trig1 = 0;
        @(negedge clk);
        chk("held_done", w_done, 1);
        chk("held_c1", w_c1, 0);
        step();

        // Zero-length start is ignored.
        start = 1; win_len = 16'd0;
        step();
        start = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("zero_busy", w_busy, 0);
            chk("zero_done", w_done, 0);
            step();
        end

        // Start during RUN is ignored: window still closes after 20 cycles.
        start = 1; win_len = 16'd20;
        step();
        start = 0;
        step(); step();
        start = 1; win_len = 16'd5;
        step();
        start = 0;
        repeat (17) step();
        @(negedge clk);
        chk("restart_done", w_done, 1);
        step();
        @(negedge clk);
        chk("restart_idle", w_busy, 0);
        step();

        // Back-to-back windows with start held high.
        start = 1; win_len = 16'd8;
        for (int k = 0; k < 40; k++) begin
            trig1 = ($urandom % 2) == 0;
            trig2 = ($urandom % 3) == 0;
            step();
        end
        start = 0; trig1 = 0; trig2 = 0;
        repeat (12) step();

        // Random traffic.
        for (int k = 0; k < 4000; k++) begin
            start = ($urandom % 8) == 0;
            win_len = (($urandom % 4) == 0) ? 16'($urandom % 120) : 16'($urandom % 24);
            stop  = ($urandom % 30) == 0;
            trig1 = ($urandom % 3) == 0;
            trig2 = ($urandom % 2) == 0;
            rst   = ($urandom % 500) == 0;
            step();
        end
        rst = 0; start = 0; stop = 0; trig1 = 0; trig2 = 0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
